// File: rtl/pp_api_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_api_pkg
//  Description : Shared widths, FSM encoding, default abort data and the
//                command record used on the pp_api register bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package pp_api_pkg;

    localparam int PP_API_ADDR_W = 12;
    localparam int PP_API_DATA_W = 32;

    // Wait counter is sized for the largest legal TIMEOUT_CYCLES (255).
    localparam int PP_API_WAIT_W = 8;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'h0;
    localparam logic [1:0] ST_ACCESS = 2'h1;
    localparam logic [1:0] ST_RESP   = 2'h2;

    // Read data returned when the slave never answers
    localparam logic [PP_API_DATA_W-1:0] PP_API_TIMEOUT_DATA = 32'hdead_dead;

    // One latched bus command
    typedef struct packed {
        logic                     we;
        logic [PP_API_ADDR_W-1:0] address;
        logic [PP_API_DATA_W-1:0] wdata;
    } pp_api_cmd_t;

endpackage
`default_nettype wire

// File: rtl/pp_api_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pp_api_arbiter
//  Description : Two-requester round-robin arbiter/sequencer in front of a
//                pp_api register slave. Serialises accesses, registers the
//                command onto the slave bus, returns read data with a
//                one-cycle ready pulse and aborts accesses the slave never
//                acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_api_arbiter
    import pp_api_pkg::*;
#(
    parameter int                         TIMEOUT_CYCLES = 16,
    parameter logic [PP_API_DATA_W-1:0]   TIMEOUT_DATA   = PP_API_TIMEOUT_DATA
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     req0_cs,
    input  logic                     req0_we,
    input  logic [PP_API_ADDR_W-1:0] req0_address,
    input  logic [PP_API_DATA_W-1:0] req0_write_data,
    output logic [PP_API_DATA_W-1:0] req0_read_data,
    output logic                     req0_ready,

    input  logic                     req1_cs,
    input  logic                     req1_we,
    input  logic [PP_API_ADDR_W-1:0] req1_address,
    input  logic [PP_API_DATA_W-1:0] req1_write_data,
    output logic [PP_API_DATA_W-1:0] req1_read_data,
    output logic                     req1_ready,

    output logic                     api_cs,
    output logic                     api_we,
    output logic [PP_API_ADDR_W-1:0] api_address,
    output logic [PP_API_DATA_W-1:0] api_write_data,
    input  logic [PP_API_DATA_W-1:0] api_read_data,
    input  logic                     api_ready,

    output logic                     timeout
);

    // Last counter value allowed in ACCESS before the access is aborted
    localparam logic [PP_API_WAIT_W-1:0] c_WAIT_LAST = PP_API_WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [PP_API_WAIT_W-1:0] r_wait_cnt;
    logic [PP_API_WAIT_W-1:0] w_wait_cnt_nxt;
    logic                     r_last_grant;
    logic                     w_last_grant_nxt;
    logic                     r_grant;
    logic                     w_grant_nxt;
    pp_api_cmd_t              r_cmd;
    pp_api_cmd_t              w_cmd_nxt;
    pp_api_cmd_t              w_win_cmd;
    logic                     r_api_cs;
    logic                     w_api_cs_nxt;
    logic                     r_req0_ready;
    logic                     w_req0_ready_nxt;
    logic                     r_req1_ready;
    logic                     w_req1_ready_nxt;
    logic                     r_timeout;
    logic                     w_timeout_nxt;
    logic [PP_API_DATA_W-1:0] r_rdata;
    logic [PP_API_DATA_W-1:0] w_rdata_nxt;

    logic                     w_any_req;
    logic                     w_win;
    logic                     w_wait_hit;

    // Two-way round robin: on a tie the requester not granted last time wins
    assign w_any_req  = req0_cs | req1_cs;
    assign w_win      = (req0_cs & req1_cs) ? ~r_last_grant : req1_cs;
    assign w_wait_hit = (r_wait_cnt == c_WAIT_LAST);

    // Select the command of the requester that wins arbitration
    always_comb begin
        w_win_cmd.we      = req0_we;
        w_win_cmd.address = req0_address;
        w_win_cmd.wdata   = req0_write_data;
        if (w_win) begin
            w_win_cmd.we      = req1_we;
            w_win_cmd.address = req1_address;
            w_win_cmd.wdata   = req1_write_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; api_ready only matters while in ACCESS
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (api_ready || w_wait_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of every registered output and datapath register
    always_comb begin
        w_wait_cnt_nxt   = r_wait_cnt;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_cmd_nxt        = r_cmd;
        w_api_cs_nxt     = 1'b0;
        w_req0_ready_nxt = 1'b0;
        w_req1_ready_nxt = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_rdata_nxt      = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt    = w_win;
                    w_cmd_nxt      = w_win_cmd;
                    w_wait_cnt_nxt = '0;
                    w_api_cs_nxt   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (api_ready) begin
                    // Writes return zero so a stale read value never leaks out
                    w_rdata_nxt      = r_cmd.we ? '0 : api_read_data;
                    w_req0_ready_nxt = ~r_grant;
                    w_req1_ready_nxt = r_grant;
                end else if (w_wait_hit) begin
                    w_rdata_nxt      = TIMEOUT_DATA;
                    w_timeout_nxt    = 1'b1;
                    w_req0_ready_nxt = ~r_grant;
                    w_req1_ready_nxt = r_grant;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                    w_api_cs_nxt   = 1'b1;
                end
            end
            ST_RESP: begin
                w_last_grant_nxt = r_grant;
            end
            default: begin
                w_last_grant_nxt = r_last_grant;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt   <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_cmd        <= '0;
            r_api_cs     <= 1'b0;
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_timeout    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_cmd        <= w_cmd_nxt;
            r_api_cs     <= w_api_cs_nxt;
            r_req0_ready <= w_req0_ready_nxt;
            r_req1_ready <= w_req1_ready_nxt;
            r_timeout    <= w_timeout_nxt;
            r_rdata      <= w_rdata_nxt;
        end
    end

    assign api_cs         = r_api_cs;
    assign api_we         = r_cmd.we;
    assign api_address    = r_cmd.address;
    assign api_write_data = r_cmd.wdata;
    assign req0_ready     = r_req0_ready;
    assign req1_ready     = r_req1_ready;
    assign req0_read_data = r_rdata;
    assign req1_read_data = r_rdata;
    assign timeout        = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pp_api_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_api_arbiter
//  Description : Self-checking bench for pp_api_arbiter with a small
//                configurable-latency pp_api slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_api_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_cs, req0_we, req1_cs, req1_we;
    logic [11:0] req0_address, req1_address;
    logic [31:0] req0_write_data, req1_write_data;
    logic [31:0] req0_read_data, req1_read_data;
    logic        req0_ready, req1_ready;
    logic        api_cs, api_we, api_ready, timeout;
    logic [11:0] api_address;
    logic [31:0] api_write_data, api_read_data;

    int total = 0;
    int bad   = 0;

    // Slave model: s_wait wait cycles before ready, 255 = never answers
    int          s_wait = 0;
    logic [7:0]  s_cnt;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    pp_api_arbiter #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_DATA   (32'hdead_dead)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req0_cs         (req0_cs),
        .req0_we         (req0_we),
        .req0_address    (req0_address),
        .req0_write_data (req0_write_data),
        .req0_read_data  (req0_read_data),
        .req0_ready      (req0_ready),
        .req1_cs         (req1_cs),
        .req1_we         (req1_we),
        .req1_address    (req1_address),
        .req1_write_data (req1_write_data),
        .req1_read_data  (req1_read_data),
        .req1_ready      (req1_ready),
        .api_cs          (api_cs),
        .api_we          (api_we),
        .api_address     (api_address),
        .api_write_data  (api_write_data),
        .api_read_data   (api_read_data),
        .api_ready       (api_ready),
        .timeout         (timeout)
    );

    // Slave wait counter and register file
    always @(posedge clk) begin
        if (!reset_n) begin
            s_cnt <= 8'd0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h7070_5f61;
        end else begin
            s_cnt <= api_cs ? s_cnt + 8'd1 : 8'd0;
            if (api_cs && api_ready && api_we) mem[api_address[5:0]] <= api_write_data;
        end
    end

    assign api_ready     = (s_wait != 255) && (s_cnt >= 8'(s_wait));
    assign api_read_data = mem[api_address[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Follows one cycle-0 launch: records ready cycle/data/timeout per
    // requester, drops each cs on its ready, and captures the first command
    // seen on the slave bus.
    task automatic watch(input int limit,
                         output int c0, output int c1,
                         output logic [31:0] d0, output logic [31:0] d1,
                         output logic t0, output logic t1, output int ncs,
                         output logic cwe, output logic [11:0] cadr, output logic [31:0] cwd);
        int   stray;
        logic seen;
        c0 = -1; c1 = -1; d0 = '0; d1 = '0; t0 = 1'b0; t1 = 1'b0;
        ncs = 0; stray = 0; seen = 1'b0; cwe = 1'b0; cadr = '0; cwd = '0;
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            if (api_cs) begin
                ncs++;
                if (!seen) begin
                    seen = 1'b1; cwe = api_we; cadr = api_address; cwd = api_write_data;
                end
            end
            if (timeout && !req0_ready && !req1_ready) stray++;
            if (req0_ready && c0 < 0) begin
                c0 = cyc; d0 = req0_read_data; t0 = timeout; req0_cs = 1'b0;
            end
            if (req1_ready && c1 < 0) begin
                c1 = cyc; d1 = req1_read_data; t1 = timeout; req1_cs = 1'b0;
            end
            if (!req0_cs && !req1_cs) break;
        end
        chk("stray_timeout", 32'(stray), 32'd0);
    endtask

    typedef struct {
        bit          who;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wd;
        int          wt;
        int          exp_cyc;
        logic [31:0] exp_data;
        logic        exp_to;
        int          exp_ncs;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int          c0, c1, ncs, nrdy, n;
        logic [31:0] d0, d1, cwd;
        logic        t0, t1, cwe;
        logic [11:0] cadr;
        int          exp_c, got_c, oth_c;
        logic [31:0] got_d;
        logic        got_t;
        int          g_who [6];
        int          g_cyc [6];

        //               who we  addr     wd            wt   cyc data          to ncs
        vecs[0] = '{1'b0, 1'b0, 12'h000, 32'h0,         0,   2, 32'h7070_5f61, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b1, 12'h020, 32'ha5a5_0001, 0,   2, 32'h0,         1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 12'h020, 32'h0,         0,   2, 32'ha5a5_0001, 1'b0, 1};
        vecs[3] = '{1'b0, 1'b0, 12'h000, 32'h0,         3,   5, 32'h7070_5f61, 1'b0, 4};
        vecs[4] = '{1'b1, 1'b0, 12'h000, 32'h0,         255, 5, 32'hdead_dead, 1'b1, 4};
        vecs[5] = '{1'b0, 1'b1, 12'h030, 32'h1234_5678, 255, 5, 32'hdead_dead, 1'b1, 4};
        vecs[6] = '{1'b0, 1'b0, 12'h030, 32'h0,         0,   2, 32'h0,         1'b0, 1};
        vecs[7] = '{1'b1, 1'b0, 12'h020, 32'h0,         2,   4, 32'ha5a5_0001, 1'b0, 3};

        reset_n = 1'b0;
        req0_cs = 1'b0; req0_we = 1'b0; req0_address = '0; req0_write_data = '0;
        req1_cs = 1'b0; req1_we = 1'b0; req1_address = '0; req1_write_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_api_cs", 32'(api_cs), 32'd0);
        chk("rst_api_address", 32'(api_address), 32'd0);
        chk("rst_ready", 32'({req0_ready, req1_ready, timeout}), 32'd0);
        chk("rst_read_data", req0_read_data | req1_read_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single-requester vectors
        for (int i = 0; i < 8; i++) begin
            s_wait = vecs[i].wt;
            if (vecs[i].who == 1'b0) begin
                req0_cs = 1'b1; req0_we = vecs[i].we; req0_address = vecs[i].addr; req0_write_data = vecs[i].wd;
                req1_cs = 1'b0; req1_we = 1'b1; req1_address = 12'hfff; req1_write_data = 32'hffff_ffff;
            end else begin
                req1_cs = 1'b1; req1_we = vecs[i].we; req1_address = vecs[i].addr; req1_write_data = vecs[i].wd;
                req0_cs = 1'b0; req0_we = 1'b1; req0_address = 12'hfff; req0_write_data = 32'hffff_ffff;
            end
            watch(20, c0, c1, d0, d1, t0, t1, ncs, cwe, cadr, cwd);
            got_c = vecs[i].who ? c1 : c0;
            oth_c = vecs[i].who ? c0 : c1;
            got_d = vecs[i].who ? d1 : d0;
            got_t = vecs[i].who ? t1 : t0;
            chk($sformatf("v%0d_ready_cycle", i), 32'(got_c), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_other_ready", i), 32'(oth_c), 32'hffff_ffff);
            chk($sformatf("v%0d_read_data", i), got_d, vecs[i].exp_data);
            chk($sformatf("v%0d_timeout", i), 32'(got_t), 32'(vecs[i].exp_to));
            chk($sformatf("v%0d_api_cs_cycles", i), 32'(ncs), 32'(vecs[i].exp_ncs));
            chk($sformatf("v%0d_api_we", i), 32'(cwe), 32'(vecs[i].we));
            chk($sformatf("v%0d_api_address", i), 32'(cadr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_api_write_data", i), cwd, vecs[i].wd);
            @(posedge clk); #1;
        end

        // Simultaneous writes: req0 wins the tie (req1 was granted last)
        s_wait = 0;
        req0_cs = 1'b1; req0_we = 1'b1; req0_address = 12'h010; req0_write_data = 32'h11;
        req1_cs = 1'b1; req1_we = 1'b1; req1_address = 12'h011; req1_write_data = 32'h22;
        watch(20, c0, c1, d0, d1, t0, t1, ncs, cwe, cadr, cwd);
        chk("tie_req0_cycle", 32'(c0), 32'd2);
        chk("tie_req1_cycle", 32'(c1), 32'd5);
        chk("tie_data", d0 | d1, 32'd0);
        chk("tie_first_address", 32'(cadr), 32'h010);
        chk("tie_api_cs_cycles", 32'(ncs), 32'd2);
        @(posedge clk); #1;
        req0_cs = 1'b1; req0_we = 1'b0; req0_address = 12'h010;
        watch(20, c0, c1, d0, d1, t0, t1, ncs, cwe, cadr, cwd);
        chk("readback_010", d0, 32'h11);
        @(posedge clk); #1;
        req1_cs = 1'b1; req1_we = 1'b0; req1_address = 12'h011;
        watch(20, c0, c1, d0, d1, t0, t1, ncs, cwe, cadr, cwd);
        chk("readback_011", d1, 32'h22);
        @(posedge clk); #1;

        // Fairness: both hold cs for six back-to-back transactions
        req0_cs = 1'b1; req0_we = 1'b0; req0_address = 12'h000;
        req1_cs = 1'b1; req1_we = 1'b0; req1_address = 12'h000;
        n = 0;
        nrdy = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) nrdy++;
            if (req0_ready || req1_ready) begin
                g_who[n] = req1_ready ? 1 : 0;
                g_cyc[n] = cyc;
                n++;
            end
        end
        req0_cs = 1'b0; req1_cs = 1'b0;
        chk("fair_count", 32'(n), 32'd6);
        chk("fair_double_ready", 32'(nrdy), 32'd0);
        for (int k = 0; k < n; k++) begin
            exp_c = 2 + 3 * k;
            chk($sformatf("fair%0d_who", k), 32'(g_who[k]), 32'(k % 2));
            chk($sformatf("fair%0d_cycle", k), 32'(g_cyc[k]), 32'(exp_c));
        end
        @(posedge clk); #1;

        // req0 served last, so only reset can hand the next tie back to req0
        req0_cs = 1'b1; req0_we = 1'b0; req0_address = 12'h000;
        watch(20, c0, c1, d0, d1, t0, t1, ncs, cwe, cadr, cwd);
        chk("pre_reset_cycle", 32'(c0), 32'd2);
        @(posedge clk); #1;

        // Reset in the middle of an ACCESS
        s_wait = 255;
        req0_cs = 1'b1; req0_we = 1'b1; req0_address = 12'h3ff; req0_write_data = 32'hcafe_f00d;
        @(negedge clk);
        @(negedge clk);
        chk("mid_access_cs", 32'(api_cs), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        req0_cs = 1'b0;
        @(negedge clk);
        chk("mid_rst_api_cs", 32'(api_cs), 32'd0);
        chk("mid_rst_api_we", 32'(api_we), 32'd0);
        chk("mid_rst_api_address", 32'(api_address), 32'd0);
        chk("mid_rst_api_write_data", api_write_data, 32'd0);
        chk("mid_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("mid_rst_read_data", req0_read_data | req1_read_data, 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        reset_n = 1'b1;
        nrdy = 0;
        ncs = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (req0_ready || req1_ready || timeout) nrdy++;
            if (api_cs) ncs++;
        end
        chk("post_rst_no_pulse", 32'(nrdy), 32'd0);
        chk("post_rst_no_cs", 32'(ncs), 32'd0);
        @(posedge clk); #1;

        // Tie after reset goes to req0
        s_wait = 0;
        req0_cs = 1'b1; req0_we = 1'b0; req0_address = 12'h000;
        req1_cs = 1'b1; req1_we = 1'b0; req1_address = 12'h011;
        watch(20, c0, c1, d0, d1, t0, t1, ncs, cwe, cadr, cwd);
        chk("post_rst_tie_req0", 32'(c0), 32'd2);
        chk("post_rst_tie_req1", 32'(c1), 32'd5);
        chk("post_rst_tie_data0", d0, 32'h7070_5f61);
        chk("post_rst_tie_data1", d1, 32'h0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
